prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 16-bit instruction-memory words.
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory address width; this matches the 8-bit pc.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a program load.
REQ-006 SHALL have port byte_valid  input  1  the source presents byte_data.
REQ-007 SHALL have port byte_data  input  8  program byte stream, high byte of each word first.
REQ-008 SHALL have port byte_ready  output  1  the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  write strobe to instruction memory.
REQ-010 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-011 SHALL have port mem_wdata  output  16  assembled instruction word.
REQ-012 SHALL have port busy  output  1  a load is in progress; the CPU is held off fetch.
REQ-013 SHALL have port done  output  1  the load ended on a halt word (16'h0000); the CPU may run.
REQ-014 SHALL have port err  output  1  memory filled before any halt word arrived.
REQ-015 SHALL have port word_count  output  ADDR_W+1  words written in the current or last load.

Function
REQ-016 SHALL implement FSM states IDLE, HI, LO, WRITE, DONE, ERR.
REQ-017 IDLE SHALL go to HI on start; mem_addr=0, word_count=0, done=0, err=0.
REQ-018 A byte transfer SHALL occur only in a cycle where byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 exactly in HI and LO; 0 in all other states.
REQ-020 HI SHALL latch byte_data into mem_wdata[15:8] on a transfer, then go to LO; with no transfer it SHALL stay in HI.
REQ-021 LO SHALL latch byte_data into mem_wdata[7:0] on a transfer, then go to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with mem_we=1; that is 1 cycle of latency after the low-byte transfer.
REQ-023 mem_we SHALL be 0 in every state other than WRITE.
REQ-024 word_count SHALL increment by 1 in WRITE.
REQ-025 In WRITE, if mem_wdata==16'h0000, the FSM SHALL go to DONE; the halt word is itself written.
REQ-026 Otherwise, if mem_addr==DEPTH-1, the FSM SHALL go to ERR: memory full with no halt word.
REQ-027 Otherwise, WRITE SHALL increment mem_addr and go to HI.
REQ-028 mem_addr SHALL never wrap within a load.
REQ-029 DONE SHALL hold done=1; ERR SHALL hold err=1; both SHALL hold until the next start.
REQ-030 A start in DONE or ERR SHALL restart the load exactly as from IDLE.
REQ-031 A start while busy (HI, LO, WRITE) SHALL be ignored.
REQ-032 busy SHALL be 1 in HI, LO and WRITE; 0 otherwise.
REQ-033 done and err SHALL never be 1 in the same cycle.
REQ-034 A halt word at address DEPTH-1 SHALL give DONE, not ERR; the halt check takes priority.
REQ-035 Bytes presented in IDLE, WRITE, DONE or ERR SHALL NOT be consumed; they are held off by byte_ready=0.

Reset
REQ-036 On any clock edge with rst_n=0, the block SHALL enter IDLE, including mid-load.
REQ-037 On reset, byte_ready, mem_we, busy, done and err SHALL be 0.
REQ-038 On reset, mem_addr, mem_wdata and word_count SHALL be 0.
REQ-039 Reset SHALL discard a partially assembled word without writing it.

Structure
REQ-040 FSM state encodings and the HALT_WORD constant (16'h0000) SHALL live in a shared package, also used by the CPU's halt detection.
REQ-041 The byte-pair assembler (HI/LO latch) SHALL be one natural sub-module, byte_pack16; everything else is a single flat module.

Verification
REQ-042 Scenario: start; stream 12 34 00 00 with valid held high -> write 16'h1234 @0, then 16'h0000 @1; done=1, word_count=2.
REQ-043 Scenario: toggle byte_valid every other cycle -> same writes as REQ-042; no byte lost or duplicated.
REQ-044 Scenario: DEPTH=4; stream 4 nonzero words -> 4 writes @0..3, then err=1, done=0, word_count=4.
REQ-045 Scenario: DEPTH=4; 3 nonzero words then 0000 -> done=1, err=0.
REQ-046 Scenario: rst_n=0 after the high byte 0xAB -> no mem_we; IDLE; all outputs 0; a fresh start loads from @0.
REQ-047 Scenario: start pulse during LO -> ignored; word_count and mem_addr sequence unchanged.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and the halt word,
// also used by the CPU's halt detection.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_e;

    localparam logic [15:0] HALT_WORD = 16'h0000;

    function automatic logic is_halt(input logic [15:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader_byte_pack16.sv
// Assembles two bytes, high byte first, into one 16-bit instruction word.
module byte_pack16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        latch_hi,
    input  logic        latch_lo,
    input  logic [7:0]  byte_data,
    output logic [15:0] word
);
    logic [15:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (latch_hi) word_d[15:8] = byte_data;
        if (latch_lo) word_d[7:0]  = byte_data;
    end

    // NOTE: reset is synchronous (sampled on the clock edge) and state uses
    // non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    end

    assign word = word_q;
endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into instruction memory as 16-bit words until a halt
// word is written (done) or memory fills without one (err).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              byte_ready;
    logic              transfer;
    logic              latch_hi, latch_lo;
    logic [15:0]       word;

    assign byte_ready = (state_q == HI) || (state_q == LO);
    assign transfer   = bus.byte_valid && byte_ready;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        word_count_d = word_count_q;
        latch_hi     = 1'b0;
        latch_lo     = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = HI;
                    mem_addr_d   = '0;
                    word_count_d = '0;
                end
            end
            HI: begin
                if (transfer) begin
                    latch_hi = 1'b1;
                    state_d  = LO;
                end
            end
            LO: begin
                if (transfer) begin
                    latch_lo = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                word_count_d = word_count_q + 1'b1;
                // Halt check wins over the full check so a halt in the last slot is a clean finish.
                if (is_halt(word))              state_d = DONE;
                else if (mem_addr_q == LAST_ADDR) state_d = ERR;
                else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                    state_d    = HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            word_count_q <= word_count_d;
        end
    end

    byte_pack16 u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .latch_hi  (latch_hi),
        .latch_lo  (latch_lo),
        .byte_data (bus.byte_data),
        .word      (word)
    );

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = word;
    assign busy           = (state_q == HI) || (state_q == LO) || (state_q == WRITE);
    assign done           = (state_q == DONE);
    assign err            = (state_q == ERR);
    assign word_count     = word_count_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-depth instance and a DEPTH=4
// instance share one stimulus driver selected by sel.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bvalid = 1'b0;
    logic [7:0] bdata = 8'h00;
    logic       sel = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(8)) if0 ();
    prog_loader_if #(.ADDR_W(8)) if1 ();
    logic       busy0, done0, err0, busy1, done1, err1;
    logic [8:0] wc0, wc1;

    assign if0.byte_valid = bvalid & ~sel;
    assign if1.byte_valid = bvalid & sel;
    assign if0.byte_data  = bdata;
    assign if1.byte_data  = bdata;

    prog_loader #(.DEPTH(256), .ADDR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .bus(if0),
        .busy(busy0), .done(done0), .err(err0), .word_count(wc0)
    );
    prog_loader #(.DEPTH(4), .ADDR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .bus(if1),
        .busy(busy1), .done(done1), .err(err1), .word_count(wc1)
    );

    logic        ready, we, busy, done, err;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [8:0]  wc;
    assign ready = sel ? if1.byte_ready : if0.byte_ready;
    assign we    = sel ? if1.mem_we     : if0.mem_we;
    assign addr  = sel ? if1.mem_addr   : if0.mem_addr;
    assign wdata = sel ? if1.mem_wdata  : if0.mem_wdata;
    assign busy  = sel ? busy1 : busy0;
    assign done  = sel ? done1 : done0;
    assign err   = sel ? err1  : err0;
    assign wc    = sel ? wc1   : wc0;

    logic [23:0] wr_log[$];
    always @(negedge clk) if (we) wr_log.push_back({addr, wdata});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        bvalid = 1'b1;
        bdata  = b;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(n), 0);
        @(negedge clk);
        bvalid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input bit gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || err) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, 32'(n < 50), 1);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [7:0] a, input logic [15:0] d);
        if (idx < wr_log.size()) check(tag, 32'(wr_log[idx]), 32'({a, d}));
        else                     check({tag, "_missing"}, 32'(wr_log.size()), 32'(idx + 1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_we"},    32'(we),    0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_err"},   32'(err),   0);
        check({tag, "_addr"},  32'(addr),  0);
        check({tag, "_wdata"}, 32'(wdata), 0);
        check({tag, "_count"}, 32'(wc),    0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic basic_load(input string tag, input bit gap);
        wr_log.delete();
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 1);
        send_word(16'h1234, gap);
        send_word(16'h0000, gap);
        wait_end(tag);
        check({tag, "_nwr"},  32'(wr_log.size()), 2);
        check_write({tag, "_w0"}, 0, 8'd0, 16'h1234);
        check_write({tag, "_w1"}, 1, 8'd1, 16'h0000);
        check({tag, "_done"},  32'(done), 1);
        check({tag, "_err"},   32'(err),  0);
        check({tag, "_count"}, 32'(wc),   2);
        check({tag, "_idle"},  32'(busy), 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        basic_load("valid_held", 1'b0);
        repeat (3) @(negedge clk);
        check("done_holds", 32'(done), 1);
        basic_load("valid_toggle", 1'b1);

        // Reset while a high byte sits in the assembler.
        wr_log.delete();
        pulse_start();
        send_byte(8'hAB, 1'b0);
        check("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_nwr", 32'(wr_log.size()), 0);
        wr_log.delete();
        pulse_start();
        send_word(16'h5566, 1'b0);
        send_word(16'h0000, 1'b0);
        wait_end("fresh");
        check_write("fresh_w0", 0, 8'd0, 16'h5566);
        check("fresh_count", 32'(wc), 2);

        // Start pulse while in LO must not disturb the load.
        wr_log.delete();
        pulse_start();
        send_byte(8'h12, 1'b0);
        pulse_start();
        send_byte(8'h34, 1'b0);
        send_word(16'h0000, 1'b0);
        wait_end("start_in_lo");
        check("lo_nwr", 32'(wr_log.size()), 2);
        check_write("lo_w0", 0, 8'd0, 16'h1234);
        check_write("lo_w1", 1, 8'd1, 16'h0000);
        check("lo_count", 32'(wc), 2);

        // DEPTH=4 instance: fill without a halt word.
        sel = 1'b1;
        do_reset();
        @(negedge clk);
        wr_log.delete();
        pulse_start();
        for (int i = 1; i <= 4; i++) send_word({8'(i), 8'(i)}, 1'b0);
        wait_end("full");
        check("full_nwr", 32'(wr_log.size()), 4);
        for (int i = 0; i < 4; i++) check_write("full_w", i, 8'(i), {8'(i + 1), 8'(i + 1)});
        check("full_err",   32'(err),  1);
        check("full_done",  32'(done), 0);
        check("full_count", 32'(wc),   4);
        bvalid = 1'b1;
        bdata  = 8'h77;
        repeat (3) begin
            @(negedge clk);
            check("err_ready", 32'(ready), 0);
        end
        bvalid = 1'b0;
        check("err_holds", 32'(err), 1);
        check("err_nwr",   32'(wr_log.size()), 4);

        // Restart from ERR; halt lands in the last slot.
        wr_log.delete();
        pulse_start();
        check("restart_err", 32'(err), 0);
        for (int i = 1; i <= 3; i++) send_word({8'(i), 8'hA0}, 1'b0);
        send_word(16'h0000, 1'b0);
        wait_end("halt_last");
        check_write("halt_last_w3", 3, 8'd3, 16'h0000);
        check("halt_last_done",  32'(done), 1);
        check("halt_last_err",   32'(err),  0);
        check("halt_last_count", 32'(wc),   4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end
endmodule
